// File: rtl/multicycle_control_fsm_if.sv
// Bundle between the multi-cycle control sequencer and the datapath/memory side.
// The sequencer takes the master modport; the datapath or a bench takes the slave.
`timescale 1ns/1ps
interface multicycle_control_fsm_if #(
  parameter int INSTRET_W = 32
);
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [2:0]           instr_type;
  logic                 branch_cond;
  logic                 imem_ready;
  logic                 dmem_ready;
  logic                 imem_req;
  logic                 ir_write;
  logic                 pc_write;
  logic [1:0]           pc_src;
  logic [1:0]           alu_src_a;
  logic                 alu_src_b;
  logic                 dmem_req;
  logic                 dmem_we;
  logic                 rf_write;
  logic [1:0]           wb_sel;
  logic [2:0]           state;
  logic                 trap;
  logic                 bus_err;
  logic [INSTRET_W-1:0] instret;

  modport master (
    input  opcode, funct3, instr_type, branch_cond, imem_ready, dmem_ready,
    output imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           dmem_req, dmem_we, rf_write, wb_sel, state, trap, bus_err, instret
  );

  modport slave (
    output opcode, funct3, instr_type, branch_cond, imem_ready, dmem_ready,
    input  imem_req, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
           dmem_req, dmem_we, rf_write, wb_sel, state, trap, bus_err, instret
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Control sequencer for the multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB
// with a terminal TRAP state, memory wait timeout, and retired-instruction count.
`timescale 1ns/1ps
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int INSTRET_W   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_control_fsm_if.master bus
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } class_t;

  state_t                state_q, state_d;
  class_t                cls_q, cls_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [INSTRET_W-1:0]  instret_q;
  logic                  trap_q, bus_err_q;
  logic                  illegal, waiting, timeout, retire;

  // Opcode-to-class decode and illegal-encoding detection, only consumed in DECODE
  always_comb begin
    cls_d = C_ALU_R;
    case (bus.opcode)
      OP_ALU_R:  cls_d = C_ALU_R;
      OP_ALU_I:  cls_d = C_ALU_I;
      OP_LOAD:   cls_d = C_LOAD;
      OP_STORE:  cls_d = C_STORE;
      OP_BRANCH: cls_d = C_BRANCH;
      OP_JAL:    cls_d = C_JAL;
      OP_JALR:   cls_d = C_JALR;
      OP_LUI:    cls_d = C_LUI;
      OP_AUIPC:  cls_d = C_AUIPC;
      default:   cls_d = C_ALU_R;
    endcase
    illegal = (bus.instr_type == 3'b111) ||
              ((bus.opcode == OP_BRANCH) && (bus.funct3[2:1] == 2'b01)) ||
              ((bus.opcode == OP_JALR) && (bus.funct3 != 3'b000));
  end

  // Memory wait detection; the final wait cycle times out only if ready is still low
  always_comb begin
    waiting = ((state_q == S_FETCH) && !bus.imem_ready) ||
              ((state_q == S_MEM) && !bus.dmem_ready);
    timeout = waiting && (cnt_q == CNT_LAST);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ready) state_d = S_DECODE;
        else if (timeout)   state_d = S_TRAP;
      end
      S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
      S_EXEC: begin
        if (cls_q == C_BRANCH)                         state_d = S_FETCH;
        else if ((cls_q == C_LOAD) || (cls_q == C_STORE)) state_d = S_MEM;
        else                                           state_d = S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ready) state_d = (cls_q == C_STORE) ? S_FETCH : S_WB;
        else if (timeout)   state_d = S_TRAP;
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
  end

  // Class latch, wait counter (cleared on every state change), sticky flags, instret
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cls_q     <= C_ALU_R;
      cnt_q     <= '0;
      trap_q    <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (state_q == S_DECODE) cls_q <= cls_d;
      if (state_d != state_q)  cnt_q <= '0;
      else if (waiting)        cnt_q <= cnt_q + 1'b1;
      if (state_d == S_TRAP)   trap_q <= 1'b1;
      if (timeout)             bus_err_q <= 1'b1;
      if (retire)              instret_q <= instret_q + 1'b1;
    end
  end

  // Output decode from state and latched class; everything forced low while in reset
  always_comb begin
    bus.imem_req  = 1'b0;
    bus.ir_write  = 1'b0;
    bus.pc_write  = 1'b0;
    bus.pc_src    = 2'd0;
    bus.alu_src_a = 2'd0;
    bus.alu_src_b = 1'b0;
    bus.dmem_req  = 1'b0;
    bus.dmem_we   = 1'b0;
    bus.rf_write  = 1'b0;
    bus.wb_sel    = 2'd0;
    retire        = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ready;
      end
      S_EXEC: begin
        case (cls_q)
          C_ALU_I, C_LOAD, C_STORE, C_JALR: bus.alu_src_b = 1'b1;
          C_AUIPC, C_JAL: begin
            bus.alu_src_a = 2'd1;
            bus.alu_src_b = 1'b1;
          end
          C_LUI: begin
            bus.alu_src_a = 2'd2;
            bus.alu_src_b = 1'b1;
          end
          C_BRANCH: begin
            bus.pc_write = 1'b1;
            bus.pc_src   = bus.branch_cond ? 2'd1 : 2'd0;
            retire       = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = (cls_q == C_STORE);
        if (bus.dmem_ready && (cls_q == C_STORE)) begin
          bus.pc_write = 1'b1;
          retire       = 1'b1;
        end
      end
      S_WB: begin
        bus.rf_write = 1'b1;
        bus.pc_write = 1'b1;
        retire       = 1'b1;
        case (cls_q)
          C_LOAD: bus.wb_sel = 2'd1;
          C_JAL: begin
            bus.wb_sel = 2'd2;
            bus.pc_src = 2'd1;
          end
          C_JALR: begin
            bus.wb_sel = 2'd2;
            bus.pc_src = 2'd2;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    if (rst) begin
      bus.imem_req  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_src    = 2'd0;
      bus.alu_src_a = 2'd0;
      bus.alu_src_b = 1'b0;
      bus.dmem_req  = 1'b0;
      bus.dmem_we   = 1'b0;
      bus.rf_write  = 1'b0;
      bus.wb_sel    = 2'd0;
      retire        = 1'b0;
    end
  end

  assign bus.state   = state_q;
  assign bus.trap    = trap_q;
  assign bus.bus_err = bus_err_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm. A second instance with a 3-bit
// retired counter shares all inputs so the counter wrap is reachable quickly.
`timescale 1ns/1ps
module tb_multicycle_control_fsm;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [2:0] instr_type;
  logic       branch_cond;
  logic       imem_ready;
  logic       dmem_ready;

  int n_chk = 0;
  int n_err = 0;

  multicycle_control_fsm_if #(.INSTRET_W(32)) bus ();
  multicycle_control_fsm_if #(.INSTRET_W(3))  bus_n ();

  assign bus.opcode        = opcode;
  assign bus.funct3        = funct3;
  assign bus.instr_type    = instr_type;
  assign bus.branch_cond   = branch_cond;
  assign bus.imem_ready    = imem_ready;
  assign bus.dmem_ready    = dmem_ready;
  assign bus_n.opcode      = opcode;
  assign bus_n.funct3      = funct3;
  assign bus_n.instr_type  = instr_type;
  assign bus_n.branch_cond = branch_cond;
  assign bus_n.imem_ready  = imem_ready;
  assign bus_n.dmem_ready  = dmem_ready;

  multicycle_control_fsm #(.MEM_TIMEOUT(16), .INSTRET_W(32)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  multicycle_control_fsm #(.MEM_TIMEOUT(16), .INSTRET_W(3)) dut_n (
    .clk(clk), .rst(rst), .bus(bus_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] strobes();
    return {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_src_a,
            bus.alu_src_b, bus.dmem_req, bus.dmem_we, bus.rf_write, bus.wb_sel};
  endfunction

  // Entered just after a negedge with the DUT in FETCH; leaves at the negedge after DECODE
  task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic [2:0] ity);
    opcode = op; funct3 = f3; instr_type = ity; imem_ready = 1'b1;
    #1;
    chk("fetch_state", 32'(bus.state), 32'd0);
    chk("fetch_ir_write", 32'(bus.ir_write), 32'd1);
    chk("fetch_imem_req", 32'(bus.imem_req), 32'd1);
    @(negedge clk);
    imem_ready = 1'b0;
    #1;
    chk("decode_state", 32'(bus.state), 32'd1);
    chk("decode_strobes", 32'(strobes()), 32'd0);
    @(negedge clk);
    opcode = 7'h7f; funct3 = 3'h7; instr_type = 3'b111;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_strobes", 32'(strobes()), 32'd0);
    chk("reset_trap", {30'd0, bus.trap, bus.bus_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_imem_req", 32'(bus.imem_req), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = '0; funct3 = '0; instr_type = '0;
    branch_cond = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("rst_strobes", 32'(strobes()), 32'd0);
    chk("rst_instret", bus.instret, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_imem_req_held", 32'(bus.imem_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("first_imem_req", 32'(bus.imem_req), 32'd1);

    // ADD x3,x1,x2
    fetch(7'b0110011, 3'b000, 3'b000);
    #1;
    chk("add_exec_state", 32'(bus.state), 32'd2);
    chk("add_exec_alu", {30'd0, bus.alu_src_a[0], bus.alu_src_b}, 32'd0);
    chk("add_exec_rf_write", 32'(bus.rf_write), 32'd0);
    @(negedge clk); #1;
    chk("add_wb_state", 32'(bus.state), 32'd4);
    chk("add_wb_strobes", {bus.rf_write, bus.pc_write, bus.pc_src, bus.wb_sel}, 32'b110000);
    chk("add_wb_instret", bus.instret, 32'd0);
    @(negedge clk); #1;
    chk("add_retire_state", 32'(bus.state), 32'd0);
    chk("add_instret", bus.instret, 32'd1);

    // BEQ taken then not taken
    fetch(7'b1100011, 3'b000, 3'b011);
    branch_cond = 1'b1;
    #1;
    chk("beq_t_exec", {bus.state, bus.pc_write, bus.pc_src, bus.rf_write}, {3'd2, 1'b1, 2'd1, 1'b0});
    @(negedge clk); #1;
    chk("beq_t_state", 32'(bus.state), 32'd0);
    chk("beq_t_instret", bus.instret, 32'd2);
    fetch(7'b1100011, 3'b001, 3'b011);
    branch_cond = 1'b0;
    #1;
    chk("beq_nt_exec", {bus.state, bus.pc_write, bus.pc_src, bus.rf_write}, {3'd2, 1'b1, 2'd0, 1'b0});
    @(negedge clk); #1;
    chk("beq_nt_instret", bus.instret, 32'd3);

    // LW with three dmem wait cycles
    fetch(7'b0000011, 3'b010, 3'b001);
    #1;
    chk("lw_exec_alu", {30'd0, bus.alu_src_a[0], bus.alu_src_b}, 32'd1);
    for (int w = 0; w < 4; w++) begin
      @(negedge clk);
      dmem_ready = (w == 3);
      #1;
      chk("lw_mem_state", 32'(bus.state), 32'd3);
      chk("lw_mem_req_we", {bus.dmem_req, bus.dmem_we, bus.pc_write}, 32'b100);
    end
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk("lw_wb", {bus.state, bus.rf_write, bus.wb_sel, bus.pc_src}, {3'd4, 1'b1, 2'd1, 2'd0});
    @(negedge clk); #1;
    chk("lw_instret", bus.instret, 32'd4);

    // SW zero wait
    fetch(7'b0100011, 3'b010, 3'b010);
    #1;
    chk("sw_exec_alu", {30'd0, bus.alu_src_a[0], bus.alu_src_b}, 32'd1);
    @(negedge clk);
    dmem_ready = 1'b1;
    #1;
    chk("sw_mem", {bus.state, bus.dmem_req, bus.dmem_we, bus.pc_write, bus.pc_src, bus.rf_write},
        {3'd3, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0});
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk("sw_retire", {bus.state, bus.instret[28:0]}, {3'd0, 29'd5});

    // JAL, JALR, LUI; narrow counter passes 7 -> 0
    fetch(7'b1101111, 3'b000, 3'b101);
    #1;
    chk("jal_exec_alu", {bus.alu_src_a, bus.alu_src_b}, 32'b011);
    @(negedge clk); #1;
    chk("jal_wb", {bus.state, bus.pc_src, bus.wb_sel, bus.rf_write}, {3'd4, 2'd1, 2'd2, 1'b1});
    @(negedge clk); #1;
    chk("jal_instret", bus.instret, 32'd6);
    fetch(7'b1100111, 3'b000, 3'b001);
    #1;
    chk("jalr_exec_alu", {bus.alu_src_a, bus.alu_src_b}, 32'b001);
    @(negedge clk); #1;
    chk("jalr_wb", {bus.state, bus.pc_src, bus.wb_sel, bus.rf_write}, {3'd4, 2'd2, 2'd2, 1'b1});
    @(negedge clk); #1;
    chk("jalr_instret", bus.instret, 32'd7);
    chk("narrow_instret_7", 32'(bus_n.instret), 32'd7);
    fetch(7'b0110111, 3'b000, 3'b100);
    #1;
    chk("lui_exec_alu", {bus.alu_src_a, bus.alu_src_b}, 32'b101);
    @(negedge clk); #1;
    chk("lui_wb", {bus.wb_sel, bus.pc_src}, 32'd0);
    @(negedge clk); #1;
    chk("lui_instret", bus.instret, 32'd8);
    chk("narrow_instret_wrap", 32'(bus_n.instret), 32'd0);

    // imem_ready arrives in the 16th FETCH cycle: no trap
    for (int k = 0; k < 14; k++) begin
      @(negedge clk); #1;
      chk("late_fetch_state", 32'(bus.state), 32'd0);
    end
    @(negedge clk);
    fetch(7'b0010011, 3'b000, 3'b001);
    #1;
    chk("addi_exec", {bus.state, bus.alu_src_a, bus.alu_src_b}, {3'd2, 2'd0, 1'b1});
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("late_no_trap", {bus.state, bus.trap, bus.bus_err}, 32'd0);
    chk("addi_instret", bus.instret, 32'd9);

    // Reset in the middle of a load's MEM wait
    fetch(7'b0000011, 3'b010, 3'b001);
    @(negedge clk);
    dmem_ready = 1'b0;
    #1;
    chk("mid_mem_req", {bus.state, bus.dmem_req}, {3'd3, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    chk("mid_mem_rst_drop", {bus.state, bus.dmem_req, bus.imem_req}, 32'd0);
    chk("mid_mem_rst_instret", bus.instret, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_mem_restart", {bus.state, bus.imem_req}, {3'd0, 1'b1});

    // Illegal instruction class traps, ignores ready, bus_err stays 0
    fetch(7'b1110011, 3'b000, 3'b111);
    #1;
    chk("ill_trap", {bus.state, bus.trap, bus.bus_err}, {3'd7, 1'b1, 1'b0});
    chk("ill_strobes", 32'(strobes()), 32'd0);
    chk("ill_instret", bus.instret, 32'd0);
    imem_ready = 1'b1; dmem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("ill_sticky", {bus.state, bus.trap}, {3'd7, 1'b1});
    imem_ready = 1'b0; dmem_ready = 1'b0;
    do_reset();

    // JALR with funct3 != 000 traps
    fetch(7'b1100111, 3'b001, 3'b001);
    #1;
    chk("jalr_f3_trap", {bus.state, bus.trap, bus.bus_err}, {3'd7, 1'b1, 1'b0});
    do_reset();

    // imem never ready: bus error after 16 FETCH cycles
    for (int k = 0; k < 15; k++) begin
      @(negedge clk); #1;
      chk("timeout_fetch_state", 32'(bus.state), 32'd0);
    end
    @(negedge clk); #1;
    chk("timeout_trap", {bus.state, bus.trap, bus.bus_err}, {3'd7, 1'b1, 1'b1});
    chk("timeout_strobes", 32'(strobes()), 32'd0);
    imem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("timeout_sticky", {bus.state, bus.trap, bus.bus_err}, {3'd7, 1'b1, 1'b1});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
